// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX-redirect flush.
// Optional stall/flush performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              ID_VALID_i,
  input  logic              FLUSH_i,
  input  logic [13:0]       CTRL_i,
  input  logic [2:0]        FUNCT3_i,
  input  logic [XLEN-1:0]   PC_i,
  input  logic [XLEN-1:0]   RD1_i,
  input  logic [XLEN-1:0]   RD2_i,
  input  logic [XLEN-1:0]   IMM_i,
  input  logic [REG_AW-1:0] RS1_i,
  input  logic [REG_AW-1:0] RS2_i,
  input  logic [REG_AW-1:0] RD_i,
  output logic              EX_VALID_o,
  output logic [13:0]       CTRL_o,
  output logic [2:0]        FUNCT3_o,
  output logic [XLEN-1:0]   PC_o,
  output logic [XLEN-1:0]   RD1_o,
  output logic [XLEN-1:0]   RD2_o,
  output logic [XLEN-1:0]   IMM_o,
  output logic [REG_AW-1:0] RS1_o,
  output logic [REG_AW-1:0] RS2_o,
  output logic [REG_AW-1:0] RD_o,
  output logic              STALL_o,
  output logic [31:0]       STALL_CNT_o,
  output logic [31:0]       FLUSH_CNT_o
);

  logic              ex_valid_q, ex_valid_d;
  logic [13:0]       ctrl_q, ctrl_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

  logic ex_is_load;
  logic load_use;
  logic stall;

  // CTRL layout: [4] = REG_WRT, [8:7] = RSLT (2'd1 selects memory load data)
  assign ex_is_load = ex_valid_q & ctrl_q[4] & (ctrl_q[8:7] == 2'd1) & (rd_q != '0);
  assign load_use   = ex_is_load & ID_VALID_i & ((rd_q == RS1_i) | (rd_q == RS2_i));
  assign stall      = load_use & ~FLUSH_i;
  assign STALL_o    = stall;

  always_comb begin
    ex_valid_d = ID_VALID_i;
    ctrl_d     = ID_VALID_i ? CTRL_i : '0;
    funct3_d   = FUNCT3_i;
    pc_d       = PC_i;
    rd1_d      = RD1_i;
    rd2_d      = RD2_i;
    imm_d      = IMM_i;
    rs1_d      = RS1_i;
    rs2_d      = RS2_i;
    rd_d       = RD_i;
    if (FLUSH_i || stall) begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
      funct3_d   = '0;
      pc_d       = '0;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
    end
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      funct3_q   <= '0;
      pc_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ctrl_q     <= ctrl_d;
      funct3_q   <= funct3_d;
      pc_q       <= pc_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign EX_VALID_o = ex_valid_q;
  assign CTRL_o     = ctrl_q;
  assign FUNCT3_o   = funct3_q;
  assign PC_o       = pc_q;
  assign RD1_o      = rd1_q;
  assign RD2_o      = rd2_q;
  assign IMM_o      = imm_q;
  assign RS1_o      = rs1_q;
  assign RS2_o      = rs2_q;
  assign RD_o       = rd_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: hold at all-ones rather than wrap
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (FLUSH_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT_o = stall_cnt_q;
  assign FLUSH_CNT_o = flush_cnt_q;
`else
  assign STALL_CNT_o = '0;
  assign FLUSH_CNT_o = '0;
`endif

endmodule
